// File: rtl/des_round_ctrl.sv
// DES round sequencer: load, per-round key rotate + f-function wait, L/R update, result handshake.
// Optional abort input is present only when DES_ROUND_CTRL_ABORT_EN is defined.
module des_round_ctrl #(
  parameter int unsigned SBOX_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       decrypt,
`ifdef DES_ROUND_CTRL_ABORT_EN
  input  logic       abort,
`endif
  output logic       busy,
  output logic       load,
  output logic       shift_en,
  output logic [1:0] key_shift,
  output logic       key_dir,
  output logic       rnd_upd,
  output logic [3:0] round,
  output logic       out_valid,
  input  logic       out_ack
);

  typedef enum logic [2:0] {IDLE, LOAD, FCALC, UPDATE, DONE} state_t;

  localparam logic [1:0] WAIT_LAST = 2'(SBOX_LAT - 1);

  state_t     state_q, state_d;
  logic [3:0] round_q, round_d;
  logic [1:0] wait_q, wait_d;
  logic       key_dir_q, key_dir_d;
  logic       busy_q, busy_d;
  logic       load_q, load_d;
  logic       shift_en_q, shift_en_d;
  logic       rnd_upd_q, rnd_upd_d;
  logic       out_valid_q, out_valid_d;

  always_comb begin
    state_d   = state_q;
    round_d   = round_q;
    wait_d    = wait_q;
    key_dir_d = key_dir_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = LOAD;
          key_dir_d = decrypt;
          round_d   = '0;
        end
      end
      LOAD: begin
        state_d = FCALC;
        wait_d  = '0;
      end
      FCALC: begin
        if (wait_q == WAIT_LAST) state_d = UPDATE;
        else                     wait_d  = wait_q + 2'd1;
      end
      UPDATE: begin
        if (round_q == 4'd15) begin
          state_d = DONE;
        end else begin
          state_d = FCALC;
          round_d = round_q + 4'd1;
          wait_d  = '0;
        end
      end
      DONE: begin
        // Ack only counts once the result is visible to the consumer.
        if (out_ack && out_valid_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef DES_ROUND_CTRL_ABORT_EN
    if (abort && (state_q inside {LOAD, FCALC, UPDATE})) begin
      state_d = IDLE;
      round_d = '0;
    end
`endif
    // Outputs registered from the next state so they align with the state register;
    // out_valid lags DONE entry by one cycle to give the result register time to settle.
    busy_d      = state_d inside {LOAD, FCALC, UPDATE};
    load_d      = (state_d == LOAD);
    shift_en_d  = (state_d == FCALC) && (state_q != FCALC);
    rnd_upd_d   = (state_d == UPDATE);
    out_valid_d = (state_q == DONE) && (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      round_q     <= '0;
      wait_q      <= '0;
      key_dir_q   <= 1'b0;
      busy_q      <= 1'b0;
      load_q      <= 1'b0;
      shift_en_q  <= 1'b0;
      rnd_upd_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      wait_q      <= wait_d;
      key_dir_q   <= key_dir_d;
      busy_q      <= busy_d;
      load_q      <= load_d;
      shift_en_q  <= shift_en_d;
      rnd_upd_q   <= rnd_upd_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Rotate schedule; decrypt skips the round-0 rotate and rotates right.
  always_comb begin
    key_shift = '0;
    if (busy_q) begin
      case (round_q)
        4'd0:                key_shift = key_dir_q ? 2'd0 : 2'd1;
        4'd1, 4'd8, 4'd15:   key_shift = 2'd1;
        default:             key_shift = 2'd2;
      endcase
    end
  end

  assign busy      = busy_q;
  assign load      = load_q;
  assign shift_en  = shift_en_q;
  assign key_dir   = key_dir_q;
  assign rnd_upd   = rnd_upd_q;
  assign round     = round_q;
  assign out_valid = out_valid_q;

endmodule
